cordic_hyperbolic_8bit: RTL and testbench
=========================================

// Module: cordic_hyperbolic_8bit
// PURPOSE
//   Pipelined 8-bit hyperbolic CORDIC in rotation mode; the activation-function datapath uses it for cosh/sinh/exp.
//   Rotates the vector (Xin,Yin) by the hyperbolic angle `angle`.
//   Result: Xout = A*(Xin*cosh(t) + Yin*sinh(t)), Yout = A*(Xin*sinh(t) + Yin*cosh(t)).
//   A = 0.82815936 is the hyperbolic CORDIC gain. Callers pre-scale Xin by 1/A.
//   Fully pipelined: accepts one sample per clock, one result per clock.
// PARAMETERS
//   SZ     8   input data/angle width; output width is SZ+1. Angle table sized for SZ=8.
//   GUARD  4   extra LSBs carried internally on X/Y/Z to limit rounding error.
// PORTS
//   clk    in   1     rising-edge clock
//   rst    in   1     synchronous, active-high reset
//   Xin    in   SZ    signed two's-complement X component
//   Yin    in   SZ    signed two's-complement Y component
//   angle  in   SZ    signed two's-complement angle in radians, Q0.7 (LSB = 2^-7), range [-1.0, +0.992]
//   Xout   out  SZ+1  signed X result, same LSB weight as Xin
//   Yout   out  SZ+1  signed Y result, same LSB weight as Yin
// BEHAVIOUR
//   - Reset: all pipeline registers clear to 0, so Xout = Yout = 0. Reset has priority over data.
//     Reset asserted mid-stream discards every in-flight sample.
//     After reset deasserts, outputs stay 0 until the first post-reset sample reaches the output.
//   - Input stage: Xin, Yin and angle are registered on every rising edge; there is no valid/handshake.
//     Inputs are sign-extended to SZ+1+GUARD bits. Angle is converted to a Z accumulator in Q1.10.
//   - Iterations: i = 1,2,3,4,4,5,6,7,8, i.e. i=4 is repeated for convergence. That is 9 stages, one register stage each.
//     d = +1 if Z >= 0, else -1.
//     X' = X + d*(Y >>> i)
//     Y' = Y + d*(X >>> i)
//     Z' = Z - d*atanh(2^-i)
//     Shifts are arithmetic.
//   - atanh ROM (Q1.10, rounded): i1=562, i2=262, i3=129, i4=64, i5=32, i6=16, i7=8, i8=4.
//     Convergence range is |t| <= 1.114 rad, which covers the whole angle input range.
//   - Output stage: drop GUARD LSBs with round-half-up.
//     Saturate to the signed SZ+1 range [-256, +255]; no wrap-around is allowed.
//   - Latency: 11 rising edges from the edge that samples the inputs to Xout/Yout valid.
//     That is 1 input register + 9 iteration stages + 1 output register.
//   - Throughput: 1 sample per cycle. Back-to-back angle changes yield back-to-back independent results.
//   - Accuracy: each output is within +/-2 LSB of the ideal A*(...) value.
//   - No internal state beyond the pipeline; the input pattern does not affect later samples.
// TESTING
//   1. angle=0, Xin=77, Yin=0, hold -> after 11 cycles Xout=64 (+/-2), Yout=0 (+/-2).
//   2. Xin=77, Yin=0, angle=64 (0.5 rad) -> Xout=72, Yout=33 (+/-2).
//      angle=-64 -> Xout=72, Yout=-33 (+/-2).
//   3. Xin=77, Yin=0, angle=-128 (-1.0 rad) -> Xout=98, Yout=-75 (+/-2).
//      angle=127 -> Xout=98, Yout=74 (+/-2).
//   4. Sweep: Xin=77, Yin=0, angle stepping -128..127, one new value per clock.
//      Each output appears exactly 11 cycles after its input and matches the ideal model within +/-2.
//      The result is even in angle for Xout and odd in angle for Yout.
//   5. Saturation: Xin=127, Yin=127, angle=127 (ideal ~284) -> Xout=255, Yout=255.
//      Xin=-128, Yin=-128, angle=127 -> Xout=-256, Yout=-256.
//   6. Reset: assert rst mid-sweep for 2 cycles -> Xout=Yout=0 on the edge after rst is sampled.
//      Outputs stay 0 until the first post-reset sample emerges 11 cycles after it is applied.

Source files
------------

// File: rtl/cordic_hyperbolic_8bit.sv
// Pipelined hyperbolic CORDIC, rotation mode. Rotates (Xin, Yin) by the
// hyperbolic angle `angle`; results carry the CORDIC gain A ~ 0.828.
// One input register, nine iteration stages (shift 4 repeated) and one
// rounding/saturating output register: 11 cycles latency, 1 sample/cycle.
module cordic_hyperbolic_8bit #(
   parameter int unsigned SZ    = 8,
   parameter int unsigned GUARD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [SZ-1:0] Xin,
   input  logic signed [SZ-1:0] Yin,
   input  logic signed [SZ-1:0] angle,
   output logic signed [SZ:0]   Xout,
   output logic signed [SZ:0]   Yout
);

   // One headroom bit beyond SZ+1+GUARD: with large inputs the rotated vector
   // exceeds the output range before saturation and must not wrap.
   localparam int unsigned W     = SZ + 2 + GUARD;
   localparam int unsigned ZFRAC = 10;
   localparam int unsigned ZW    = ZFRAC + 2;
   localparam int unsigned NS    = 9;

   typedef logic signed [W-1:0]  dat_t;
   typedef logic signed [ZW-1:0] ang_t;

   // Stage k (0-based) uses shift 1,2,3,4,4,5,6,7,8.
   function automatic int unsigned shift_of(int unsigned k);
      return (k < 4) ? k + 1 : k;
   endfunction

   // atanh(2^-i) in Q1.10, rounded.
   function automatic ang_t atanh_rom(int unsigned i);
      ang_t v;
      case (i)
         1:       v = ang_t'(562);
         2:       v = ang_t'(262);
         3:       v = ang_t'(129);
         4:       v = ang_t'(64);
         5:       v = ang_t'(32);
         6:       v = ang_t'(16);
         7:       v = ang_t'(8);
         8:       v = ang_t'(4);
         default: v = '0;
      endcase
      return v;
   endfunction

   // Drop the guard bits with round-half-up, then clamp to the output range.
   function automatic logic signed [SZ:0] round_sat(dat_t v);
      dat_t r;
      logic signed [SZ:0] o;
      r = (v + dat_t'(2 ** (GUARD - 1))) >>> GUARD;
      if (r > dat_t'(2 ** SZ - 1)) begin
         o = {1'b0, {SZ{1'b1}}};
      end else if (r < -dat_t'(2 ** SZ)) begin
         o = {1'b1, {SZ{1'b0}}};
      end else begin
         o = r[SZ:0];
      end
      return o;
   endfunction

   dat_t x_q [NS+1];
   dat_t y_q [NS+1];
   ang_t z_q [NS+1];
   dat_t x_d [NS+1];
   dat_t y_d [NS+1];
   ang_t z_d [NS+1];
   logic signed [SZ:0] xout_q, yout_q, xout_d, yout_d;

   // Input alignment and the nine micro-rotations feeding each register stage.
   always_comb begin
      x_d[0] = dat_t'(Xin) <<< GUARD;
      y_d[0] = dat_t'(Yin) <<< GUARD;
      z_d[0] = ang_t'(angle) <<< (ZFRAC - (SZ - 1));
      for (int unsigned k = 1; k <= NS; k++) begin
         if (!z_q[k-1][ZW-1]) begin
            x_d[k] = x_q[k-1] + (y_q[k-1] >>> shift_of(k - 1));
            y_d[k] = y_q[k-1] + (x_q[k-1] >>> shift_of(k - 1));
            z_d[k] = z_q[k-1] - atanh_rom(shift_of(k - 1));
         end else begin
            x_d[k] = x_q[k-1] - (y_q[k-1] >>> shift_of(k - 1));
            y_d[k] = y_q[k-1] - (x_q[k-1] >>> shift_of(k - 1));
            z_d[k] = z_q[k-1] + atanh_rom(shift_of(k - 1));
         end
      end
      xout_d = round_sat(x_q[NS]);
      yout_d = round_sat(y_q[NS]);
   end

   // Pipeline registers; synchronous reset flushes every in-flight sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k <= NS; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
            z_q[k] <= '0;
         end
         xout_q <= '0;
         yout_q <= '0;
      end else begin
         for (int unsigned k = 0; k <= NS; k++) begin
            x_q[k] <= x_d[k];
            y_q[k] <= y_d[k];
            z_q[k] <= z_d[k];
         end
         xout_q <= xout_d;
         yout_q <= yout_d;
      end
   end

   assign Xout = xout_q;
   assign Yout = yout_q;

endmodule

// File: tb/tb_cordic_hyperbolic_8bit.sv
// Bench for cordic_hyperbolic_8bit: directed cases, an angle sweep with a
// mid-stream reset, and random vectors, all checked against an ideal
// real-valued cosh/sinh model delayed by the pipeline latency.
module tb_cordic_hyperbolic_8bit;

   localparam real A   = 0.82815936;
   localparam int  LAT = 11;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [7:0] Xin, Yin, angle;
   logic signed [8:0] Xout, Yout;

   int checks = 0;
   int errors = 0;

   typedef struct {int x; int y; int a; bit v;} samp_t;
   samp_t pipe[$];

   cordic_hyperbolic_8bit dut (
      .clk   (clk),
      .rst   (rst),
      .Xin   (Xin),
      .Yin   (Yin),
      .angle (angle),
      .Xout  (Xout),
      .Yout  (Yout)
   );

   always #5 clk = ~clk;

   function automatic real ideal(int x, int y, int a, bit is_y);
      real t, ch, sh, v;
      t  = a / 128.0;
      ch = ($exp(t) + $exp(-t)) / 2.0;
      sh = ($exp(t) - $exp(-t)) / 2.0;
      v  = is_y ? A * (x * sh + y * ch) : A * (x * ch + y * sh);
      if (v > 255.0) v = 255.0;
      if (v < -256.0) v = -256.0;
      return v;
   endfunction

   task automatic chk_tol(string tag, int obs, real exp_v);
      real  diff;
      logic ok;
      diff = obs - exp_v;
      ok = (diff <= 2.0 && diff >= -2.0);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0.2f (+/-2)", tag, obs, exp_v);
      end
   endtask

   task automatic chk_exact(string tag, int obs, int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // One clock: drive inputs, let the edge sample them, then compare the
   // outputs with the sample that entered LAT edges earlier.
   task automatic tick(input int x, input int y, input int a, input bit r);
      samp_t e;
      Xin   = x[7:0];
      Yin   = y[7:0];
      angle = a[7:0];
      rst   = r;
      @(posedge clk);
      pipe.push_back('{x, y, a, !r});
      if (r) begin
         foreach (pipe[i]) pipe[i].v = 1'b0;
      end
      #1;
      e = pipe.pop_front();
      if (e.v) begin
         chk_tol("model_x", int'(Xout), ideal(e.x, e.y, e.a, 1'b0));
         chk_tol("model_y", int'(Yout), ideal(e.x, e.y, e.a, 1'b1));
      end else begin
         chk_exact("flushed_x", int'(Xout), 0);
         chk_exact("flushed_y", int'(Yout), 0);
      end
   endtask

   task automatic hold(input int x, input int y, input int a);
      repeat (LAT) tick(x, y, a, 1'b0);
   endtask

   initial begin
      rst   = 1'b1;
      Xin   = '0;
      Yin   = '0;
      angle = '0;
      repeat (LAT - 1) pipe.push_back('{0, 0, 0, 1'b0});

      repeat (3) tick(0, 0, 0, 1'b1);
      chk_exact("reset_x", int'(Xout), 0);
      chk_exact("reset_y", int'(Yout), 0);

      // Latency: still zero after 10 edges, result on the 11th.
      repeat (LAT - 1) tick(77, 0, 0, 1'b0);
      chk_exact("lat_early_x", int'(Xout), 0);
      tick(77, 0, 0, 1'b0);
      chk_tol("t1_x", int'(Xout), 64.0);
      chk_tol("t1_y", int'(Yout), 0.0);

      hold(77, 0, 64);
      chk_tol("t2p_x", int'(Xout), 72.0);
      chk_tol("t2p_y", int'(Yout), 33.0);
      hold(77, 0, -64);
      chk_tol("t2n_x", int'(Xout), 72.0);
      chk_tol("t2n_y", int'(Yout), -33.0);

      hold(77, 0, -128);
      chk_tol("t3n_x", int'(Xout), 98.0);
      chk_tol("t3n_y", int'(Yout), -75.0);
      hold(77, 0, 127);
      chk_tol("t3p_x", int'(Xout), 98.0);
      chk_tol("t3p_y", int'(Yout), 74.0);

      hold(127, 127, 127);
      chk_exact("sat_pos_x", int'(Xout), 255);
      chk_exact("sat_pos_y", int'(Yout), 255);
      hold(-128, -128, 127);
      chk_exact("sat_neg_x", int'(Xout), -256);
      chk_exact("sat_neg_y", int'(Yout), -256);

      // Back-to-back sweep of every angle.
      for (int a = -128; a <= 127; a++) tick(77, 0, a, 1'b0);

      // Sweep again with a two-cycle reset in the middle.
      for (int a = -128; a <= 127; a++) tick(77, 0, a, (a == 0 || a == 1));

      // Random vectors over the full input range.
      for (int n = 0; n < 300; n++) begin
         tick(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128, 1'b0);
      end

      repeat (LAT) tick(0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
